// File: rtl/display_share_ctrl_if.sv
// Display sharing bus: two requesters' level requests and digit data in,
// grants, digit outputs and owner-change pulse out.
interface display_share_ctrl_if;
  logic        req_a;
  logic [15:0] data_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [3:0]  number0;
  logic [3:0]  number1;
  logic [3:0]  number2;
  logic [3:0]  number3;
  logic        owner_chg;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, number0, number1, number2, number3, owner_chg
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, number0, number1, number2, number3, owner_chg
  );
endinterface

// File: rtl/display_share_ctrl.sv
// Arbitrates a four-digit seven-segment display between two requesters,
// with a minimum dwell per owner and round-robin tie breaking.
module display_share_ctrl #(
  parameter int unsigned DWELL      = 4,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  display_share_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_num;
  logic             r_last_b;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_owner_chg;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_num_nxt;
  logic             w_last_b_nxt;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_MAX);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num       <= IDLE_VALUE;
      r_last_b    <= 1'b1;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_owner_chg <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_num       <= w_num_nxt;
      r_last_b    <= w_last_b_nxt;
      r_gnt_a     <= (w_state_nxt == S_OWN_A);
      r_gnt_b     <= (w_state_nxt == S_OWN_B);
      r_owner_chg <= (w_state_nxt != r_state);
    end
  end

  // Next owner, dwell count and digit value; a non-owner's data is never looked at.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_num_nxt    = r_num;
    w_last_b_nxt = r_last_b;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_num_nxt = IDLE_VALUE;
        if (bus.req_a && (!bus.req_b || r_last_b)) begin
          w_state_nxt  = S_OWN_A;
          w_num_nxt    = bus.data_a;
          w_last_b_nxt = 1'b0;
        end else if (bus.req_b) begin
          w_state_nxt  = S_OWN_B;
          w_num_nxt    = bus.data_b;
          w_last_b_nxt = 1'b1;
        end
      end
      S_OWN_A: begin
        if (!w_expired) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (bus.req_a) w_num_nxt = bus.data_a;
        end else if (bus.req_b) begin
          w_state_nxt  = S_OWN_B;
          w_cnt_nxt    = '0;
          w_num_nxt    = bus.data_b;
          w_last_b_nxt = 1'b1;
        end else if (bus.req_a) begin
          w_num_nxt = bus.data_a;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_num_nxt   = IDLE_VALUE;
        end
      end
      S_OWN_B: begin
        if (!w_expired) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (bus.req_b) w_num_nxt = bus.data_b;
        end else if (bus.req_a) begin
          w_state_nxt  = S_OWN_A;
          w_cnt_nxt    = '0;
          w_num_nxt    = bus.data_a;
          w_last_b_nxt = 1'b0;
        end else if (bus.req_b) begin
          w_num_nxt = bus.data_b;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_num_nxt   = IDLE_VALUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_num_nxt   = IDLE_VALUE;
      end
    endcase
  end

  assign bus.gnt_a     = r_gnt_a;
  assign bus.gnt_b     = r_gnt_b;
  assign bus.owner_chg = r_owner_chg;
  assign bus.number0   = r_num[3:0];
  assign bus.number1   = r_num[7:4];
  assign bus.number2   = r_num[11:8];
  assign bus.number3   = r_num[15:12];

endmodule

// File: tb/tb_display_share_ctrl.sv
// Directed bench for display_share_ctrl: a vector table on a DWELL=4 instance
// and a short hand sequence on a DWELL=1 instance with a non-zero idle value.
module tb_display_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  display_share_ctrl_if bus ();
  display_share_ctrl_if bus2 ();

  display_share_ctrl #(.DWELL(4), .IDLE_VALUE(16'h0000)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  display_share_ctrl #(.DWELL(1), .IDLE_VALUE(16'hFEDC)) dut2 (
    .clock   (clk),
    .reset_n (rst2_n),
    .bus     (bus2.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        ra;
    logic [15:0] da;
    logic        rb;
    logic [15:0] db;
    logic        ga;
    logic        gb;
    logic        chg;
    logic [15:0] num;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic ra, input logic [15:0] da,
                     input logic rb, input logic [15:0] db,
                     input logic ga, input logic gb, input logic chg,
                     input logic [15:0] num);
    vec_t v;
    v.rst_n = r; v.ra = ra; v.da = da; v.rb = rb; v.db = db;
    v.ga = ga; v.gb = gb; v.chg = chg; v.num = num;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx,
                            input logic ga, input logic gb, input logic chg,
                            input logic [15:0] num,
                            input logic ega, input logic egb, input logic echg,
                            input logic [15:0] enum_v);
    check({tag, ".gnt_a"}, idx, 16'(ga), 16'(ega));
    check({tag, ".gnt_b"}, idx, 16'(gb), 16'(egb));
    check({tag, ".owner_chg"}, idx, 16'(chg), 16'(echg));
    check({tag, ".numbers"}, idx, num, enum_v);
    check({tag, ".excl"}, idx, 16'(ga & gb), 16'h0);
  endtask

  // Drive dut2 for one edge and compare its outputs just after the edge.
  task automatic step2(input int idx, input logic r, input logic ra, input logic [15:0] da,
                       input logic rb, input logic [15:0] db,
                       input logic ega, input logic egb, input logic echg,
                       input logic [15:0] enum_v);
    rst2_n = r; bus2.req_a = ra; bus2.data_a = da; bus2.req_b = rb; bus2.data_b = db;
    @(posedge clk); #1;
    check_outs("d1", idx, bus2.gnt_a, bus2.gnt_b, bus2.owner_chg,
               {bus2.number3, bus2.number2, bus2.number1, bus2.number0},
               ega, egb, echg, enum_v);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.req_a = 1'b0; bus.data_a = '0; bus.req_b = 1'b0; bus.data_b = '0;
    bus2.req_a = 1'b0; bus2.data_a = '0; bus2.req_b = 1'b0; bus2.data_b = '0;

    //  rst ra  data_a    rb  data_b    ga gb chg num
    add(0, 1, 16'hA842, 0, 16'h0000,  0, 0, 0, 16'h0000); // reset ignores req_a
    add(1, 1, 16'hA842, 0, 16'h0000,  1, 0, 1, 16'hA842); // first grant after release
    add(1, 1, 16'hA842, 1, 16'h5555,  1, 0, 0, 16'hA842); // B waits, its data ignored
    add(1, 1, 16'hA842, 1, 16'h5556,  1, 0, 0, 16'hA842);
    add(1, 1, 16'hA842, 1, 16'h5557,  1, 0, 0, 16'hA842);
    add(1, 1, 16'hA842, 1, 16'h5558,  0, 1, 1, 16'h5558); // A held 4 cycles, direct to B
    add(1, 1, 16'hA842, 1, 16'h6666,  0, 1, 0, 16'h6666);
    add(1, 1, 16'hA842, 1, 16'h6666,  0, 1, 0, 16'h6666);
    add(1, 1, 16'hA842, 1, 16'h6666,  0, 1, 0, 16'h6666);
    add(1, 1, 16'h1111, 1, 16'h6666,  1, 0, 1, 16'h1111); // alternation back to A
    add(1, 0, 16'h2222, 0, 16'h0000,  1, 0, 0, 16'h1111); // req dropped: frozen, held
    add(1, 0, 16'h3333, 0, 16'h0000,  1, 0, 0, 16'h1111);
    add(1, 0, 16'h3333, 0, 16'h0000,  1, 0, 0, 16'h1111);
    add(1, 0, 16'h3333, 0, 16'h0000,  0, 0, 1, 16'h0000); // expiry, both low -> idle
    add(1, 0, 16'h3333, 0, 16'h0000,  0, 0, 0, 16'h0000);
    add(1, 1, 16'h1234, 1, 16'hABCD,  0, 1, 1, 16'hABCD); // tie, last owner A -> B
    add(1, 0, 16'h1234, 1, 16'hABCE,  0, 1, 0, 16'hABCE);
    add(1, 0, 16'h1234, 1, 16'hABCE,  0, 1, 0, 16'hABCE);
    add(1, 0, 16'h1234, 1, 16'hABCE,  0, 1, 0, 16'hABCE);
    add(1, 0, 16'h1234, 1, 16'hABCF,  0, 1, 0, 16'hABCF); // saturated, stays
    add(1, 0, 16'h1234, 1, 16'hABCF,  0, 1, 0, 16'hABCF);
    add(1, 1, 16'h7777, 1, 16'hABCF,  1, 0, 1, 16'h7777); // A granted on first raise
    add(1, 1, 16'h1234, 0, 16'h0000,  1, 0, 0, 16'h1234); // data follow, no pulse
    add(1, 1, 16'h5678, 0, 16'h0000,  1, 0, 0, 16'h5678);
    add(1, 1, 16'h5678, 0, 16'h0000,  1, 0, 0, 16'h5678);
    add(1, 0, 16'h5678, 1, 16'h9999,  0, 1, 1, 16'h9999);
    add(1, 0, 16'h5678, 1, 16'h9999,  0, 1, 0, 16'h9999);
    add(0, 1, 16'h5678, 1, 16'h9999,  0, 0, 0, 16'h0000); // reset mid-dwell in OWN_B
    add(1, 1, 16'h4321, 1, 16'h8888,  1, 0, 1, 16'h4321); // tie after reset -> A
    add(1, 1, 16'h4321, 0, 16'h8888,  1, 0, 0, 16'h4321);
    add(0, 1, 16'h4321, 1, 16'h8888,  0, 0, 0, 16'h0000); // reset while last owner is A
    add(1, 1, 16'h0F0F, 1, 16'hF0F0,  1, 0, 1, 16'h0F0F); // last owner back to B
    add(1, 0, 16'h0F0F, 0, 16'h0000,  1, 0, 0, 16'h0F0F);
    add(1, 0, 16'h0F0F, 0, 16'h0000,  1, 0, 0, 16'h0F0F);
    add(1, 0, 16'h0F0F, 0, 16'h0000,  1, 0, 0, 16'h0F0F);
    add(1, 0, 16'h0F0F, 0, 16'h0000,  0, 0, 1, 16'h0000);
    add(1, 0, 16'h0000, 1, 16'hBEEF,  0, 1, 1, 16'hBEEF); // lone B from idle

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      bus.req_a = vecs[i].ra; bus.data_a = vecs[i].da;
      bus.req_b = vecs[i].rb; bus.data_b = vecs[i].db;
      @(posedge clk); #1;
      check_outs("d4", i, bus.gnt_a, bus.gnt_b, bus.owner_chg,
                 {bus.number3, bus.number2, bus.number1, bus.number0},
                 vecs[i].ga, vecs[i].gb, vecs[i].chg, vecs[i].num);
    end

    // DWELL=1: ownership may change on every edge; idle shows FEDC.
    step2(0, 0, 1, 16'h1111, 1, 16'h2222,  0, 0, 0, 16'hFEDC);
    step2(1, 1, 1, 16'h1111, 1, 16'h2222,  1, 0, 1, 16'h1111);
    step2(2, 1, 1, 16'h1111, 1, 16'h2222,  0, 1, 1, 16'h2222);
    step2(3, 1, 1, 16'h1111, 1, 16'h2222,  1, 0, 1, 16'h1111);
    step2(4, 1, 0, 16'h1111, 0, 16'h2222,  0, 0, 1, 16'hFEDC);
    step2(5, 1, 1, 16'h3333, 0, 16'h2222,  1, 0, 1, 16'h3333);
    step2(6, 1, 1, 16'h4444, 0, 16'h2222,  1, 0, 0, 16'h4444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_share_ctrl.md
DISPLAY_SHARE_CTRL -- requirements
Module: display_share_ctrl

Interface
REQ-001 Parameter DWELL, default 4, minimum cycles an owner holds the display once granted (legal range 1..65535).
REQ-002 Parameter IDLE_VALUE, default 16'h0000, digits shown when no requester owns the display ([3:0]=digit 0 ... [15:12]=digit 3).
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_a  input  1  requester A wants the display; level, held while needed.
REQ-006 data_a  input  16  requester A digits, nibble k -> digit k.
REQ-007 req_b  input  1  requester B wants the display; level.
REQ-008 data_b  input  16  requester B digits, nibble k -> digit k.
REQ-009 gnt_a  output  1  A owns the display; registered.
REQ-010 gnt_b  output  1  B owns the display; registered; never high together with gnt_a.
REQ-011 number0..number3  output  4 each  digit values to the seven-segment scan driver; registered.
REQ-012 owner_chg  output  1  one-cycle pulse on every change of owner, including to/from idle.

Function
REQ-013 FSM states: IDLE, OWN_A, OWN_B; gnt_a high exactly in OWN_A, gnt_b high exactly in OWN_B.
REQ-014 IDLE: numbers = IDLE_VALUE nibbles; dwell counter = 0.
REQ-015 IDLE, req sampled high at edge t -> owner state entered, gnt high and numbers loaded from that requester's data at edge t (visible the cycle after sampling); latency 1 cycle.
REQ-016 IDLE, req_a and req_b both high -> grant the requester that was NOT last_owner; last_owner resets to B, so A wins the first tie.
REQ-017 In OWN_x with req_x high, numbers reload from data_x every cycle (1-cycle registered follow).
REQ-018 In OWN_x with req_x low, numbers hold last loaded value (no reload, no blanking).
REQ-019 Dwell counter: 0 on owner-state entry; increments each cycle in the owner state; saturates at DWELL-1.
REQ-020 Dwell expired = counter == DWELL-1; before expiry the owner state is held regardless of either req.
REQ-021 After expiry, other requester high -> switch directly to the other owner state in one edge; counter to 0; numbers load other's data; last_owner updated; no IDLE cycle in between.
REQ-022 After expiry, other low and own req high -> stay; counter stays saturated; other requester granted the first cycle it raises req.
REQ-023 After expiry, both low -> IDLE; numbers load IDLE_VALUE at that edge.
REQ-024 owner_chg is high for exactly the cycle following each state change (same cycle the new gnt/numbers first appear).
REQ-025 Data inputs are ignored for a requester that is not owner; no buffering of pending data.
REQ-026 Counter width = ceiling(log2(DWELL)), minimum 1 bit; DWELL=1 allows a switch on every edge.

Reset
REQ-027 reset_n low at an edge -> next cycle: state IDLE, gnt_a=0, gnt_b=0, owner_chg=0, counter=0, last_owner=B, numbers=IDLE_VALUE.
REQ-028 Reset overrides everything, including mid-dwell ownership; req inputs on the reset edge are ignored; first grant is possible on the first edge with reset_n high.

Verification
REQ-029 Reset with req_a=1 -> gnt_a=0, numbers=0,0,0,0; first edge after release -> gnt_a=1, owner_chg=1, numbers = data_a nibbles (data_a=16'hA842 -> number3..0 = A,8,4,2).
REQ-030 DWELL=4: A granted, B raises req 1 cycle later -> gnt_a stays 4 cycles total, then gnt_b=1 with no gap, owner_chg pulses once, numbers = data_b.
REQ-031 Both req raised together from reset -> A granted; after A's dwell with both still high -> B; after B's dwell -> A (strict alternation).
REQ-032 A granted, req_a dropped after 1 cycle, data_a changed -> numbers frozen at the first value until dwell expiry, then IDLE_VALUE and gnt_a=0.
REQ-033 A owns, data_a steps 1234->5678 -> numbers follow one cycle later with no owner_chg pulse.
REQ-034 reset_n low mid-dwell in OWN_B -> next cycle all outputs at reset values, last_owner=B; simultaneous req_a/req_b after release -> A granted.
